sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 2: cycles spent on each 16-bit half-word phase (legal range 1..15).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port MEM_R_EN, input, 1: 32-bit read request from the MEM stage.
REQ-005 SHALL have port MEM_W_EN, input, 1: 32-bit write request from the MEM stage.
REQ-006 SHALL have port address, input, 16: word address from the MEM stage address generator.
REQ-007 SHALL have port writeData, input, 32: store data.
REQ-008 SHALL have port readData, output, 32: registered load data.
REQ-009 SHALL have port SRAM_NOT_READY, output, 1: pipeline freeze request.
REQ-010 SHALL have port SRAMaddress, output, 18: SRAM half-word address.
REQ-011 SHALL have port SRAMWEn, output, 1: SRAM write enable, active-low.
REQ-012 SHALL have port SRAMOEn, output, 1: SRAM output enable, active-low.
REQ-013 SHALL have port SRAMdata, inout, 16: SRAM data bus.

Function
REQ-014 SHALL implement states IDLE, LOW, HIGH and DONE, with a phase counter of 4 bits.
REQ-015 In IDLE with MEM_R_EN or MEM_W_EN high, the block SHALL capture address, writeData and op (write if MEM_W_EN, else read), clear the counter, and go to LOW on the next edge.
REQ-016 SHALL give write priority when MEM_R_EN and MEM_W_EN are both high; the access SHALL be a write.
REQ-017 SHALL stay in LOW for PHASE_CYCLES cycles, then go to HIGH and clear the counter.
REQ-018 SHALL stay in HIGH for PHASE_CYCLES cycles, then go to DONE.
REQ-019 SHALL go from DONE to IDLE unconditionally after one cycle; a request present in DONE SHALL be ignored until IDLE.
REQ-020 SRAM_NOT_READY SHALL be combinational: (IDLE and (MEM_R_EN or MEM_W_EN)) or LOW or HIGH.
REQ-021 The stall SHALL therefore last 1+2*PHASE_CYCLES cycles, with DONE the release cycle.
REQ-022 SRAMaddress SHALL be {1'b0, captured address, 1'b0} in LOW and {1'b0, captured address, 1'b1} in HIGH, else 18'b0.
REQ-023 Write, LOW: SRAMdata SHALL carry writeData[15:0]; HIGH: writeData[31:16]; SRAMWEn SHALL be low for the whole of both phases.
REQ-024 Read: SRAMWEn SHALL be high and SRAMOEn low in LOW/HIGH; SRAMdata SHALL be high-impedance.
REQ-025 Outside write LOW/HIGH, SRAMdata SHALL be high-impedance; SRAMOEn SHALL be high outside read LOW/HIGH.
REQ-026 Read: SRAMdata SHALL be sampled on the last cycle of LOW into a low-half register and on the last cycle of HIGH into readData[31:16]; readData[15:0] SHALL load from the low-half register on the same edge.
REQ-027 readData SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-028 Input changes after capture SHALL NOT affect the access in progress.

Reset
REQ-029 rst low SHALL immediately force IDLE; counter 0; readData 32'b0; SRAMaddress 0; SRAMWEn 1; SRAMOEn 1; SRAMdata Z; SRAM_NOT_READY 0 unless a request is present.
REQ-030 Reset mid-access SHALL abort the access with no partial readData update; after release, a held request SHALL start a fresh access.

Verification
REQ-031 Write, address 16'h0004, data 32'hDEADBEEF, PHASE_CYCLES=2 -> SRAMaddress 18'h00008 with bus 16'hBEEF for 2 cycles, then 18'h00009 with 16'hDEAD for 2 cycles; SRAMWEn low 4 cycles; SRAM_NOT_READY high exactly 5 cycles.
REQ-032 Read back the same address from an SRAM model -> readData 32'hDEADBEEF in DONE; SRAMdata never driven by the block; SRAMOEn low 4 cycles.
REQ-033 MEM_R_EN and MEM_W_EN both high, data 32'h12345678 -> write performed; readData unchanged.
REQ-034 rst pulsed low during HIGH of a read -> outputs at reset values within the reset cycle; readData 0; state IDLE.
REQ-035 Back-to-back requests held continuously -> DONE cycle has SRAM_NOT_READY 0; second access begins from IDLE next cycle; total 6 cycles per access.
REQ-036 PHASE_CYCLES=1 -> stall of 3 cycles; both halves are correct.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: serves 32-bit MEM-stage loads/stores over a 16-bit SRAM as two half-word phases,
// freezing the pipeline until the access completes.
module sram_controller #(
    parameter int PHASE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [15:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        SRAM_NOT_READY,
    output logic [17:0] SRAMaddress,
    output logic        SRAMWEn,
    output logic        SRAMOEn,
    inout  wire  [15:0] SRAMdata
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam logic [3:0] LAST = 4'(PHASE_CYCLES - 1);
    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [15:0] addr_q, lo_q;
    logic [31:0] wd_q;
    logic        wr_q, busy, hi, last;
    assign busy = state == LOW || state == HIGH;
    assign hi   = state == HIGH;
    assign last = cnt == LAST;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            wd_q     <= '0;
            wr_q     <= 1'b0;
            lo_q     <= '0;
            readData <= '0;
        end else begin
            case (state)
                IDLE: if (MEM_R_EN || MEM_W_EN) begin
                    addr_q <= address;
                    wd_q   <= writeData;
                    wr_q   <= MEM_W_EN;
                    cnt    <= '0;
                    state  <= LOW;
                end
                LOW: if (last) begin
                    state <= HIGH;
                    cnt   <= '0;
                    if (!wr_q) lo_q <= SRAMdata;
                end else cnt <= cnt + 4'd1;
                HIGH: if (last) begin
                    state <= DONE;
                    if (!wr_q) readData <= {SRAMdata, lo_q};
                end else cnt <= cnt + 4'd1;
                default: state <= IDLE;
            endcase
        end
    end
    assign SRAM_NOT_READY = busy || (state == IDLE && (MEM_R_EN || MEM_W_EN));
    assign SRAMaddress    = busy ? {1'b0, addr_q, hi} : 18'b0;
    assign SRAMWEn        = !(busy && wr_q);
    assign SRAMOEn        = !(busy && !wr_q);
    assign SRAMdata       = (busy && wr_q) ? (hi ? wd_q[31:16] : wd_q[15:0]) : 16'bz;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed vector table plus hand sequences for reset, back-to-back and single-cycle phases.
module tb_sram_controller;
    logic        clk = 1'b0, rst = 1'b0;
    logic        rd, wr, r2, w2;
    logic [15:0] addr, a2;
    logic [31:0] wd, d2;
    logic [31:0] rdata1, rdata2;
    logic        stall1, stall2, wen1, wen2, oen1, oen2;
    logic [17:0] sa1, sa2;
    wire  [15:0] bus1, bus2;
    logic [15:0] mem1 [256];
    logic [15:0] mem2 [256];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    sram_controller #(.PHASE_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst), .MEM_R_EN(rd), .MEM_W_EN(wr), .address(addr), .writeData(wd),
        .readData(rdata1), .SRAM_NOT_READY(stall1), .SRAMaddress(sa1), .SRAMWEn(wen1),
        .SRAMOEn(oen1), .SRAMdata(bus1)
    );
    sram_controller #(.PHASE_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .MEM_R_EN(r2), .MEM_W_EN(w2), .address(a2), .writeData(d2),
        .readData(rdata2), .SRAM_NOT_READY(stall2), .SRAMaddress(sa2), .SRAMWEn(wen2),
        .SRAMOEn(oen2), .SRAMdata(bus2)
    );

    assign bus1 = !oen1 ? mem1[sa1[7:0]] : 16'bz;
    assign bus2 = !oen2 ? mem2[sa2[7:0]] : 16'bz;
    always @(posedge clk) begin
        if (!wen1) mem1[sa1[7:0]] <= bus1;
        if (!wen2) mem2[sa2[7:0]] <= bus2;
    end

    typedef struct {
        logic        rd, wr;
        logic [15:0] addr;
        logic [31:0] wd;
        logic        stall;
        logic [17:0] sa;
        logic        wen, oen, chk_bus;
        logic [15:0] bus;
        logic [31:0] rdata;
    } vec_t;
    vec_t v [18];

    function automatic vec_t mk(logic r, logic w, logic [15:0] a, logic [31:0] d, logic s,
                                logic [17:0] sa, logic we, logic oe, logic cb, logic [15:0] b,
                                logic [31:0] rdv);
        vec_t t;
        t.rd = r; t.wr = w; t.addr = a; t.wd = d; t.stall = s; t.sa = sa;
        t.wen = we; t.oen = oe; t.chk_bus = cb; t.bus = b; t.rdata = rdv;
        return t;
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // write DEADBEEF @4, read it back, then simultaneous rd+wr of 12345678 @8
        v[0]  = mk(0, 1, 16'h0004, 32'hDEADBEEF, 1, 18'h0,  1, 1, 0, 16'h0,    32'h0);
        v[1]  = mk(0, 0, 16'h0055, 32'h0,        1, 18'h8,  0, 1, 1, 16'hBEEF, 32'h0);
        v[2]  = mk(0, 0, 16'h0055, 32'h0,        1, 18'h8,  0, 1, 1, 16'hBEEF, 32'h0);
        v[3]  = mk(0, 0, 16'h0055, 32'h0,        1, 18'h9,  0, 1, 1, 16'hDEAD, 32'h0);
        v[4]  = mk(0, 0, 16'h0055, 32'h0,        1, 18'h9,  0, 1, 1, 16'hDEAD, 32'h0);
        v[5]  = mk(0, 0, 16'h0055, 32'h0,        0, 18'h0,  1, 1, 0, 16'h0,    32'h0);
        v[6]  = mk(1, 0, 16'h0004, 32'h0F0F0F0F, 1, 18'h0,  1, 1, 0, 16'h0,    32'h0);
        v[7]  = mk(0, 0, 16'h0033, 32'h0,        1, 18'h8,  1, 0, 1, 16'hBEEF, 32'h0);
        v[8]  = mk(0, 0, 16'h0033, 32'h0,        1, 18'h8,  1, 0, 1, 16'hBEEF, 32'h0);
        v[9]  = mk(0, 0, 16'h0033, 32'h0,        1, 18'h9,  1, 0, 1, 16'hDEAD, 32'h0);
        v[10] = mk(0, 0, 16'h0033, 32'h0,        1, 18'h9,  1, 0, 1, 16'hDEAD, 32'h0);
        v[11] = mk(0, 0, 16'h0033, 32'h0,        0, 18'h0,  1, 1, 0, 16'h0,    32'hDEADBEEF);
        v[12] = mk(1, 1, 16'h0008, 32'h12345678, 1, 18'h0,  1, 1, 0, 16'h0,    32'hDEADBEEF);
        v[13] = mk(0, 0, 16'h0000, 32'h0,        1, 18'h10, 0, 1, 1, 16'h5678, 32'hDEADBEEF);
        v[14] = mk(0, 0, 16'h0000, 32'h0,        1, 18'h10, 0, 1, 1, 16'h5678, 32'hDEADBEEF);
        v[15] = mk(0, 0, 16'h0000, 32'h0,        1, 18'h11, 0, 1, 1, 16'h1234, 32'hDEADBEEF);
        v[16] = mk(0, 0, 16'h0000, 32'h0,        1, 18'h11, 0, 1, 1, 16'h1234, 32'hDEADBEEF);
        v[17] = mk(0, 0, 16'h0000, 32'h0,        0, 18'h0,  1, 1, 0, 16'h0,    32'hDEADBEEF);

        rd = 0; wr = 0; addr = 0; wd = 0; r2 = 0; w2 = 0; a2 = 0; d2 = 0;
        #1;
        chk("rst_rdata", rdata1, 32'h0);
        chk("rst_sa", 32'(sa1), 32'h0);
        chk("rst_wen", 32'(wen1), 32'h1);
        chk("rst_oen", 32'(oen1), 32'h1);
        chk("rst_stall", 32'(stall1), 32'h0);
        wr = 1;
        #1;
        chk("rst_stall_req", 32'(stall1), 32'h1);
        wr = 0;
        step();
        step();
        rst = 1;

        for (int i = 0; i < 18; i++) begin
            rd = v[i].rd; wr = v[i].wr; addr = v[i].addr; wd = v[i].wd;
            #1;
            chk($sformatf("v%0d_stall", i), 32'(stall1), 32'(v[i].stall));
            chk($sformatf("v%0d_sa", i), 32'(sa1), 32'(v[i].sa));
            chk($sformatf("v%0d_wen", i), 32'(wen1), 32'(v[i].wen));
            chk($sformatf("v%0d_oen", i), 32'(oen1), 32'(v[i].oen));
            chk($sformatf("v%0d_rdata", i), rdata1, v[i].rdata);
            if (v[i].chk_bus) chk($sformatf("v%0d_bus", i), 32'(bus1), 32'(v[i].bus));
            step();
        end

        // back-to-back reads held continuously: 5 stall cycles then a DONE release, repeating
        rd = 1; wr = 0; addr = 16'h0004;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk($sformatf("b2b%0d_stall", i), 32'(stall1), (i % 6 == 5) ? 32'h0 : 32'h1);
            if (i % 6 == 1) chk($sformatf("b2b%0d_sa", i), 32'(sa1), 32'h8);
            if (i % 6 == 5) chk($sformatf("b2b%0d_rdata", i), rdata1, 32'hDEADBEEF);
            step();
        end

        // reset during HIGH of a read aborts it; a held request afterwards starts fresh
        addr = 16'h0008;
        step();
        step();
        step();
        chk("abort_in_high", 32'(sa1), 32'h11);
        rd = 0;
        rst = 0;
        #1;
        chk("abort_rdata", rdata1, 32'h0);
        chk("abort_sa", 32'(sa1), 32'h0);
        chk("abort_wen", 32'(wen1), 32'h1);
        chk("abort_oen", 32'(oen1), 32'h1);
        chk("abort_stall", 32'(stall1), 32'h0);
        step();
        rst = 1;
        rd = 1;
        #1;
        chk("restart_stall", 32'(stall1), 32'h1);
        step();
        chk("restart_sa", 32'(sa1), 32'h10);
        chk("restart_oen", 32'(oen1), 32'h0);
        rd = 0;
        for (int i = 0; i < 4; i++) step();
        chk("restart_stall_done", 32'(stall1), 32'h0);
        chk("restart_rdata", rdata1, 32'h12345678);

        // single-cycle phases: write then read A5A55A5A @2
        w2 = 1; a2 = 16'h0002; d2 = 32'hA5A55A5A;
        #1;
        chk("p1w_stall0", 32'(stall2), 32'h1);
        step();
        w2 = 0; a2 = 0; d2 = 0;
        #1;
        chk("p1w_lo_sa", 32'(sa2), 32'h4);
        chk("p1w_lo_bus", 32'(bus2), 32'h5A5A);
        chk("p1w_lo_wen", 32'(wen2), 32'h0);
        step();
        chk("p1w_hi_sa", 32'(sa2), 32'h5);
        chk("p1w_hi_bus", 32'(bus2), 32'hA5A5);
        chk("p1w_hi_stall", 32'(stall2), 32'h1);
        step();
        chk("p1w_done_stall", 32'(stall2), 32'h0);
        chk("p1w_rdata", rdata2, 32'h0);
        step();
        r2 = 1; a2 = 16'h0002;
        #1;
        chk("p1r_stall0", 32'(stall2), 32'h1);
        step();
        r2 = 0;
        #1;
        chk("p1r_lo_oen", 32'(oen2), 32'h0);
        chk("p1r_lo_stall", 32'(stall2), 32'h1);
        step();
        chk("p1r_hi_sa", 32'(sa2), 32'h5);
        step();
        chk("p1r_done_stall", 32'(stall2), 32'h0);
        chk("p1r_rdata", rdata2, 32'hA5A55A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
